// File: rtl/wb_debug_splitter_pkg.sv
// Shared types and helpers for the Wishbone debug splitter: FSM state encoding,
// debug-bank register offsets and the byte-lane write mask.
package wb_debug_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DBG  = 2'd1,
    USER = 2'd2,
    TOUT = 2'd3
  } state_t;

  // The status word is always the last word of the bank, the user-access count just below it.
  function automatic int unsigned status_idx(input int unsigned num_regs);
    return num_regs - 1;
  endfunction

  function automatic int unsigned ucount_idx(input int unsigned num_regs);
    return num_regs - 2;
  endfunction

  function automatic logic [31:0] byte_mask(input logic [3:0] sel);
    logic [31:0] mask;
    mask = '0;
    for (int i = 0; i < 4; i++) begin
      mask[8*i +: 8] = {8{sel[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/wb_debug_splitter_if.sv
// Wishbone slave-side bundle between the caravel port, the splitter and the gated user slave.
interface wb_debug_splitter_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        user_cyc_o;
  logic        user_ack_i;
  logic [31:0] user_dat_i;

  // Splitter's view of the bus.
  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  user_ack_i, user_dat_i,
    output wbs_ack_o, wbs_dat_o, user_cyc_o
  );

  // Environment view: management master plus user slave.
  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output user_ack_i, user_dat_i,
    input  wbs_ack_o, wbs_dat_o, user_cyc_o
  );
endinterface

// File: rtl/wb_debug_regbank.sv
// Debug register bank: RW scratch words, RO user-access counter and the status word
// carrying the block id and a saturating timeout count.
module wb_debug_regbank
  import wb_debug_pkg::*;
#(
  parameter int unsigned NUM_REGS = 4,
  parameter logic [15:0] BLOCK_ID = 16'hD5B1,
  parameter int unsigned IDX_W    = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wr_data,
  input  logic [3:0]       wr_sel,
  input  logic             user_inc,
  input  logic             tout_inc,
  output logic [31:0]      rd_data
);

  localparam int unsigned STATUS_IDX = status_idx(NUM_REGS);
  localparam int unsigned UCOUNT_IDX = ucount_idx(NUM_REGS);

  logic [NUM_REGS-1:0][31:0] word_val;
  logic [31:0]               ucount_reg;
  logic [15:0]               tout_cnt_reg;
  logic [31:0]               lane_mask;

  assign lane_mask = byte_mask(wr_sel);

  genvar gi;
  generate
    for (gi = 0; gi < int'(NUM_REGS) - 2; gi++) begin : g_scratch
      logic [31:0] scratch_reg;
      always_ff @(posedge clk) begin
        if (srst) begin
          scratch_reg <= '0;
        end else if (wr_en && idx == IDX_W'(gi)) begin
          scratch_reg <= (scratch_reg & ~lane_mask) | (wr_data & lane_mask);
        end
      end
      assign word_val[gi] = scratch_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (srst) begin
      ucount_reg <= '0;
    end else if (user_inc) begin
      ucount_reg <= ucount_reg + 32'd1;
    end
  end

  // A clearing write takes priority over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (srst) begin
      tout_cnt_reg <= '0;
    end else if (wr_en && idx == IDX_W'(STATUS_IDX)) begin
      tout_cnt_reg <= '0;
    end else if (tout_inc && tout_cnt_reg != 16'hFFFF) begin
      tout_cnt_reg <= tout_cnt_reg + 16'd1;
    end
  end

  assign word_val[UCOUNT_IDX] = ucount_reg;
  assign word_val[STATUS_IDX] = {BLOCK_ID, tout_cnt_reg};
  assign rd_data              = word_val[idx];

endmodule

// File: rtl/wb_debug_splitter.sv
// Splits the user Wishbone window: the top NUM_REGS words go to a debug bank, the rest
// to the user slave with gated cyc and an ack watchdog.
module wb_debug_splitter
  import wb_debug_pkg::*;
#(
  parameter int unsigned NUM_REGS       = 4,
  parameter logic [31:0] WINDOW_END     = 32'h3010_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF,
  parameter logic [15:0] BLOCK_ID       = 16'hD5B1
) (
  input logic               wb_clk_i,
  input logic               wb_rst_i,
  wb_debug_splitter_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(NUM_REGS);
  localparam logic [31:0] BASE  = WINDOW_END - 32'(4 * NUM_REGS);
  localparam int unsigned WD_W  = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic             we_reg, we_next;
  logic [WD_W-1:0]  wd_cnt_reg, wd_cnt_next;

  logic        hit;
  logic        ack;
  logic [31:0] dat;
  logic        user_cyc;
  logic        bank_wr;
  logic        user_inc;
  logic        tout_inc;
  logic [31:0] bank_rd;
  logic        unused_adr_bits;

  assign hit             = (bus.wbs_adr_i[31:2+IDX_W] == BASE[31:2+IDX_W]);
  assign unused_adr_bits = ^bus.wbs_adr_i[1:0];

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg  <= IDLE;
      idx_reg    <= '0;
      we_reg     <= 1'b0;
      wd_cnt_reg <= '0;
    end else begin
      state_reg  <= state_next;
      idx_reg    <= idx_next;
      we_reg     <= we_next;
      wd_cnt_reg <= wd_cnt_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    idx_next    = idx_reg;
    we_next     = we_reg;
    wd_cnt_next = wd_cnt_reg;
    ack         = 1'b0;
    dat         = '0;
    user_cyc    = 1'b0;
    bank_wr     = 1'b0;
    user_inc    = 1'b0;
    tout_inc    = 1'b0;
    case (state_reg)
      IDLE: begin
        // Target is latched here so the ack/data path never follows the live address.
        if (bus.wbs_cyc_i && bus.wbs_stb_i) begin
          if (hit) begin
            state_next = DBG;
            idx_next   = bus.wbs_adr_i[2 +: IDX_W];
            we_next    = bus.wbs_we_i;
          end else begin
            state_next  = USER;
            wd_cnt_next = '0;
            user_inc    = 1'b1;
          end
        end
      end
      DBG: begin
        ack        = 1'b1;
        dat        = bank_rd;
        bank_wr    = we_reg;
        state_next = IDLE;
      end
      USER: begin
        user_cyc = bus.wbs_cyc_i;
        ack      = bus.user_ack_i;
        dat      = bus.user_dat_i;
        // Ack beats the watchdog limit; an abandoned cycle is never counted as a timeout.
        if (bus.user_ack_i || !bus.wbs_cyc_i) begin
          state_next = IDLE;
        end else if (TIMEOUT_CYCLES != 0 && wd_cnt_reg == WD_W'(TIMEOUT_CYCLES)) begin
          state_next = TOUT;
        end else begin
          wd_cnt_next = wd_cnt_reg + 1'b1;
        end
      end
      TOUT: begin
        ack        = 1'b1;
        dat        = TIMEOUT_DATA;
        tout_inc   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.wbs_ack_o  = ack;
  assign bus.wbs_dat_o  = dat;
  assign bus.user_cyc_o = user_cyc;

  wb_debug_regbank #(
    .NUM_REGS (NUM_REGS),
    .BLOCK_ID (BLOCK_ID),
    .IDX_W    (IDX_W)
  ) u_regbank (
    .clk      (wb_clk_i),
    .srst     (wb_rst_i),
    .wr_en    (bank_wr),
    .idx      (idx_reg),
    .wr_data  (bus.wbs_dat_i),
    .wr_sel   (bus.wbs_sel_i),
    .user_inc (user_inc),
    .tout_inc (tout_inc),
    .rd_data  (bank_rd)
  );

endmodule

// File: tb/tb_wb_debug_splitter.sv
// Directed self-checking bench for wb_debug_splitter (NUM_REGS=4, TIMEOUT_CYCLES=8).
module tb_wb_debug_splitter;
  import wb_debug_pkg::*;

  localparam logic [31:0] W0   = 32'h300F_FFF0;
  localparam logic [31:0] W1   = 32'h300F_FFF4;
  localparam logic [31:0] W2   = 32'h300F_FFF8;
  localparam logic [31:0] W3   = 32'h300F_FFFC;
  localparam logic [31:0] UADR = 32'h3000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  // User slave model: acks after ack_after wait cycles when enabled.
  bit          slave_en  = 1'b0;
  int          ack_after = 0;
  int          wait_cnt  = 0;
  logic [31:0] user_dat  = '0;

  wb_debug_splitter_if bus ();

  wb_debug_splitter #(
    .NUM_REGS       (4),
    .WINDOW_END     (32'h3010_0000),
    .TIMEOUT_CYCLES (8),
    .TIMEOUT_DATA   (32'hDEAD_BEEF),
    .BLOCK_ID       (16'hD5B1)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.user_cyc_o && !bus.user_ack_i) wait_cnt <= wait_cnt + 1;
    else                                   wait_cnt <= 0;
  end

  assign bus.user_ack_i = slave_en && bus.user_cyc_o && (wait_cnt == ack_after);
  assign bus.user_dat_i = user_dat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One Wishbone transfer; lat counts negedges from drive to ack, ucyc counts user_cyc_o-high samples.
  task automatic xfer(input string tag, input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                      input logic [3:0] sel, output logic [31:0] rdat, output int lat, output int ucyc);
    bit got;
    got  = 1'b0;
    lat  = 0;
    ucyc = 0;
    rdat = 'x;
    @(negedge clk);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = wdat;
    bus.wbs_sel_i = sel;
    while (!got && lat < 50) begin
      @(negedge clk);
      lat++;
      if (bus.user_cyc_o) ucyc++;
      if (bus.wbs_ack_o) begin
        got  = 1'b1;
        rdat = bus.wbs_dat_o;
      end
    end
    check({tag, "_acked"}, 32'(got), 32'd1);
    @(posedge clk);
    #1;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    $display("xfer %-12s adr=%h we=%0d wdat=%h sel=%h -> rdat=%h lat=%0d ucyc=%0d",
             tag, adr, we, wdat, sel, rdat, lat, ucyc);
  endtask

  task automatic rd(input string tag, input logic [31:0] adr, input logic [31:0] exp);
    logic [31:0] d;
    int l, u;
    xfer(tag, adr, 1'b0, 32'h0, 4'hF, d, l, u);
    check(tag, d, exp);
  endtask

  task automatic wr(input string tag, input logic [31:0] adr, input logic [31:0] wdat, input logic [3:0] sel);
    logic [31:0] d;
    int l, u;
    xfer(tag, adr, 1'b1, wdat, sel, d, l, u);
    check({tag, "_lat"}, 32'(l), 32'd1);
  endtask

  task automatic check_bank_cleared(input string tag);
    rd({tag, "_w0"}, W0, 32'h0);
    rd({tag, "_w1"}, W1, 32'h0);
    rd({tag, "_w2"}, W2, 32'h0);
    rd({tag, "_w3"}, W3, 32'hD5B1_0000);
  endtask

  initial begin
    logic [31:0] d;
    int l, u;

    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'h0;
    bus.wbs_adr_i = '0;
    bus.wbs_dat_i = '0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ack", 32'(bus.wbs_ack_o), 32'd0);
    check("rst_dat", bus.wbs_dat_o, 32'h0);
    check("rst_ucyc", 32'(bus.user_cyc_o), 32'd0);

    // Scratch word writes with full and partial byte selects.
    wr("w0_full", W0, 32'h1234_5678, 4'hF);
    rd("w0_rd", W0, 32'h1234_5678);
    wr("w0_lane1", W0, 32'hAABB_CCDD, 4'b0010);
    rd("w0_merge", W0, 32'h1234_CC78);
    wr("w1_lanes", W1, 32'h55AA_55AA, 4'b1001);
    rd("w1_merge", W1, 32'h5500_00AA);

    // User read, slave acks after 3 wait cycles.
    slave_en  = 1'b1;
    ack_after = 3;
    user_dat  = 32'hCAFE_0001;
    xfer("user_rd", UADR, 1'b0, 32'h0, 4'hF, d, l, u);
    check("user_dat", d, 32'hCAFE_0001);
    check("user_lat", 32'(l), 32'd4);
    check("user_cyc_len", 32'(u), 32'd4);
    rd("ucount_1", W2, 32'd1);
    wr("ucount_wr", W2, 32'hFFFF_FFFF, 4'hF);
    rd("ucount_ro", W2, 32'd1);

    // Absent user slave: watchdog fires on the 9th USER cycle.
    slave_en = 1'b0;
    xfer("tout", UADR, 1'b0, 32'h0, 4'hF, d, l, u);
    check("tout_dat", d, 32'hDEAD_BEEF);
    check("tout_lat", 32'(l), 32'd10);
    rd("status_1", W3, 32'hD5B1_0001);
    wr("status_clr", W3, 32'h0000_1234, 4'hF);
    rd("status_0", W3, 32'hD5B1_0000);

    // Ack on exactly the limit cycle wins over the timeout.
    slave_en  = 1'b1;
    ack_after = 8;
    user_dat  = 32'hCAFE_0002;
    xfer("ack_limit", UADR, 1'b0, 32'h0, 4'hF, d, l, u);
    check("ack_limit_dat", d, 32'hCAFE_0002);
    check("ack_limit_lat", 32'(l), 32'd9);
    rd("status_still0", W3, 32'hD5B1_0000);

    // Master abandons a user access, then immediately reads the bank.
    slave_en = 1'b0;
    @(negedge clk);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_adr_i = UADR;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_noack", 32'(bus.wbs_ack_o), 32'd0);
    end
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    #1;
    check("abort_ucyc", 32'(bus.user_cyc_o), 32'd0);
    check("abort_drop_ack", 32'(bus.wbs_ack_o), 32'd0);
    $display("xfer abort       adr=%h dropped after 3 cycles", UADR);
    xfer("abort_status", W3, 1'b0, 32'h0, 4'hF, d, l, u);
    check("abort_status_dat", d, 32'hD5B1_0000);
    check("abort_status_lat", 32'(l), 32'd1);
    rd("ucount_4", W2, 32'd4);

    // Second timeout so the resets have a non-zero count to clear.
    xfer("tout2", UADR, 1'b0, 32'h0, 4'hF, d, l, u);
    check("tout2_dat", d, 32'hDEAD_BEEF);
    rd("status_1b", W3, 32'hD5B1_0001);
    rd("ucount_5", W2, 32'd5);

    // Reset while in USER.
    @(negedge clk);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_adr_i = UADR;
    repeat (2) @(negedge clk);
    check("pre_rst_ucyc", 32'(bus.user_cyc_o), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_user_ack", 32'(bus.wbs_ack_o), 32'd0);
    check("rst_user_ucyc", 32'(bus.user_cyc_o), 32'd0);
    check("rst_user_state", 32'(dut.state_reg), 32'(IDLE));
    rst = 1'b0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    $display("xfer reset_user  reset asserted during USER");
    check_bank_cleared("rst_user");

    // Reset while in DBG.
    wr("w0_refill", W0, 32'h0BAD_F00D, 4'hF);
    @(negedge clk);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_adr_i = W0;
    @(negedge clk);
    check("pre_rst_dbg_ack", 32'(bus.wbs_ack_o), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_dbg_ack", 32'(bus.wbs_ack_o), 32'd0);
    check("rst_dbg_ucyc", 32'(bus.user_cyc_o), 32'd0);
    check("rst_dbg_state", 32'(dut.state_reg), 32'(IDLE));
    rst = 1'b0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    $display("xfer reset_dbg   reset asserted during DBG");
    check_bank_cleared("rst_dbg");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_debug_splitter.md
Name: wb_debug_splitter

Overview:
- Parametrised successor to the fixed two-register debug split in the user wrapper.
- Sits between the caravel Wishbone slave port and the user project.
- Reserves the top NUM_REGS words of the user window for a debug register bank. All other addresses go to the user slave, with its cyc gated.
- Adds a user-slave ack watchdog with timeout reporting, so a hung or absent user slave can no longer stall the management core.

Parameters:
- NUM_REGS, 4: number of debug words; power of two, >=2.
- WINDOW_END, 32'h3010_0000: first address above the user window. The debug bank starts at WINDOW_END-4*NUM_REGS.
- TIMEOUT_CYCLES, 255: user-slave ack watchdog limit in cycles; 0 disables the watchdog.
- TIMEOUT_DATA, 32'hDEAD_BEEF: read data returned on a timed-out access.
- BLOCK_ID, 16'hD5B1: constant reported in the status register.

Ports:
- wb_clk_i  in  1  sole clock
- wb_rst_i  in  1  synchronous, active-high reset
- wbs_cyc_i  in  1  master cycle
- wbs_stb_i  in  1  master strobe
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  4  byte selects
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  ack to master
- wbs_dat_o  out  32  read data to master
- user_cyc_o  out  1  gated cyc to user slave; stb/we/sel/adr/dat are wired directly to the user slave outside this block
- user_ack_i  in  1  user slave ack
- user_dat_i  in  32  user slave read data

Behaviour:
- Clock and reset: one clock, wb_clk_i. Reset wb_rst_i is synchronous and active-high.
- Reset values:
  - state = IDLE; all debug registers = 0; timeout count = 0; watchdog counter = 0.
  - wbs_ack_o = 0, wbs_dat_o = 0, user_cyc_o = 0.
- Hit decode: hit = (wbs_adr_i[31:2+log2(NUM_REGS)] == base[31:2+log2(NUM_REGS)]); register index = wbs_adr_i[2+log2(NUM_REGS)-1:2].
- Registered target: the hit is latched at accept time. The ack/data mux uses the latched target, never the live address.
- State IDLE:
  - cyc&stb&hit -> DBG.
  - cyc&stb&!hit -> USER, watchdog counter cleared.
  - user_cyc_o = 0 in IDLE.
- State DBG (exactly one cycle):
  - wbs_ack_o = 1.
  - Reads: wbs_dat_o = selected register.
  - Writes: commit at this edge, per byte lane where wbs_sel_i is set.
  - Next state IDLE. Debug latency is therefore 1 wait cycle; back-to-back accesses are accepted every 2 cycles.
- Register map:
  - Words 0..NUM_REGS-3: RW scratch.
  - Word NUM_REGS-2: RO, count of user accesses that reached USER state (wrapping 32-bit). Writes are ignored.
  - Word NUM_REGS-1: status = {BLOCK_ID, timeout_count[15:0]}. Any write clears timeout_count.
  - With NUM_REGS=2 the bank has no scratch words.
- State USER:
  - user_cyc_o = wbs_cyc_i.
  - wbs_ack_o = user_ack_i and wbs_dat_o = user_dat_i, combinationally.
  - user_ack_i -> IDLE.
  - wbs_cyc_i dropped -> IDLE; no timeout is counted.
  - If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES with no ack -> TOUT.
  - The user-access counter increments on entry to USER.
- State TOUT (one cycle):
  - user_cyc_o = 0; wbs_ack_o = 1; wbs_dat_o = TIMEOUT_DATA.
  - timeout_count increments, saturating at 16'hFFFF.
  - Next state IDLE.
- Simultaneous events:
  - user_ack_i in the same cycle the counter hits its limit: the ack wins and no timeout is counted.
  - A clearing write to the status register during DBG wins over any increment.
- Reset mid-operation: wb_rst_i in any state returns to IDLE next edge, drops ack and user_cyc_o, and clears all registers.
- wbs_ack_o is never asserted outside DBG, TOUT, or a USER-state user_ack_i.

Decomposition:
- Package wb_debug_pkg holds:
  - state enum {IDLE, DBG, USER, TOUT};
  - register-offset constants (status = NUM_REGS-1, user count = NUM_REGS-2);
  - the byte-lane write-mask helper.
- One natural sub-module: wb_debug_regbank, containing the register array, byte-select writes, read mux and counters. The FSM, decode and watchdog stay in the top module.

Test Plan:
- Write 0x1234_5678 sel=4'hF to 0x300F_FFF0 (NUM_REGS=4, word 0), then read it back -> ack 1 cycle after accept; read returns 0x1234_5678. Write 0xAABB_CCDD sel=4'b0010 -> reads 0x1234_CC78.
- User read at 0x3000_0000 with the user slave acking after 3 cycles, data 0xCAFE_0001 -> user_cyc_o high for 4 cycles; master sees ack and 0xCAFE_0001. Word 2 (0x300F_FFF8) reads 1.
- User slave never acks, TIMEOUT_CYCLES=8 -> ack with 0xDEAD_BEEF; status at 0x300F_FFFC reads 0xD5B1_0001. Write any value to the status word -> status reads 0xD5B1_0000.
- user_ack_i asserted exactly on the limit cycle -> user data returned; timeout_count stays 0.
- Master drops cyc mid-USER, then issues a debug read immediately -> no ack for the aborted access; debug read acked normally; timeout_count unchanged.
- Assert wb_rst_i during USER and separately during DBG -> next cycle ack=0, user_cyc_o=0, state IDLE; all registers read 0 except the status upper half (BLOCK_ID).
